// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for a 2**W entry FIFO whose storage
// lives in an external register file. The controller only produces the
// write enable, the addresses and the occupancy status.
module fifo_ctrl #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [W-1:0] r_addr,
  output logic         full,
  output logic         empty,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  logic [W-1:0] w_ptr;
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_ptr_nxt;
  logic [W-1:0] r_ptr_nxt;
  logic         wr_acc;
  logic         rd_acc;

  // Request acceptance and incremented pointers (wrap is the natural
  // modulo-2**W rollover of a W-bit counter).
  always_comb begin
    wr_acc    = wr & ~full;
    rd_acc    = rd & ~empty;
    w_ptr_nxt = w_ptr + W'(1);
    r_ptr_nxt = r_ptr + W'(1);
  end

  // Addresses come straight from the pointer registers, so there is no
  // combinational path from wr/rd to the register-file addresses.
  always_comb begin
    wr_en  = wr_acc;
    w_addr = w_ptr;
    r_addr = r_ptr;
  end

  // Pointer, occupancy and flag registers; reset wins over any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // A dropped request pulses its error flag even if the other side of
      // the same cycle is accepted.
      overflow  <= wr & full;
      underflow <= rd & empty;
      case ({wr_acc, rd_acc})
        2'b10: begin
          w_ptr <= w_ptr_nxt;
          count <= count + (W+1)'(1);
          empty <= 1'b0;
          full  <= (w_ptr_nxt == r_ptr);
        end
        2'b01: begin
          r_ptr <= r_ptr_nxt;
          count <= count - (W+1)'(1);
          full  <= 1'b0;
          empty <= (r_ptr_nxt == w_ptr);
        end
        2'b11: begin
          w_ptr <= w_ptr_nxt;
          r_ptr <= r_ptr_nxt;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl (W=2). A count-based
// reference model predicts each cycle's registered outputs; predictions
// are queued when stimulus is driven and popped after the clock edge.
module tb_fifo_ctrl;

  localparam int unsigned W = 2;
  localparam int D = 1 << W;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         wr = 1'b0;
  logic         rd = 1'b0;
  logic         wr_en;
  logic [W-1:0] w_addr;
  logic [W-1:0] r_addr;
  logic         full;
  logic         empty;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;

  fifo_ctrl #(.W(W)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .wr_en(wr_en),
    .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int wa;
    int ra;
    bit ful;
    bit emp;
    bit ovf;
    bit udf;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // model state
  int m_cnt = 0;
  int m_w = 0;
  int m_r = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check wr_en, predict, clock, compare.
  task automatic step(input bit rst, input bit w, input bit r);
    exp_t e;
    bit wa, ra;
    reset = rst;
    wr    = w;
    rd    = r;
    #1;
    check("wr_en", {31'b0, wr_en}, {31'b0, w && (m_cnt != D)});
    if (rst) begin
      m_cnt = 0; m_w = 0; m_r = 0;
      e.ovf = 0; e.udf = 0;
    end else begin
      wa = w && (m_cnt < D);
      ra = r && (m_cnt > 0);
      e.ovf = w && (m_cnt == D);
      e.udf = r && (m_cnt == 0);
      if (wa) begin m_w = (m_w + 1) % D; m_cnt++; end
      if (ra) begin m_r = (m_r + 1) % D; m_cnt--; end
    end
    e.cnt = m_cnt;
    e.wa  = m_w;
    e.ra  = m_r;
    e.ful = (m_cnt == D);
    e.emp = (m_cnt == 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("count",     32'(count),     32'(e.cnt));
      check("w_addr",    32'(w_addr),    32'(e.wa));
      check("r_addr",    32'(r_addr),    32'(e.ra));
      check("full",      32'(full),      32'(e.ful));
      check("empty",     32'(empty),     32'(e.emp));
      check("overflow",  32'(overflow),  32'(e.ovf));
      check("underflow", 32'(underflow), 32'(e.udf));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    step(1, 0, 0);
    step(1, 0, 0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);

    // fill: four accepted writes
    repeat (4) step(0, 1, 0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    check("fill_waddr", 32'(w_addr), 32'd0);

    // write while full: dropped, overflow one cycle
    step(0, 1, 0);
    check("ovf_pulse", 32'(overflow), 32'd1);
    step(0, 0, 0);
    check("ovf_clear", 32'(overflow), 32'd0);

    // drain, then read while empty
    repeat (4) step(0, 0, 1);
    check("drain_empty", 32'(empty), 32'd1);
    step(0, 0, 1);
    check("udf_pulse", 32'(underflow), 32'd1);
    check("udf_raddr", 32'(r_addr), 32'd0);
    step(0, 0, 0);
    check("udf_clear", 32'(underflow), 32'd0);

    // count=2, then simultaneous wr/rd with wrap
    repeat (2) step(0, 1, 0);
    repeat (3) step(0, 1, 1);
    check("sim_count", 32'(count), 32'd2);
    check("sim_waddr", 32'(w_addr), 32'd1);
    check("sim_raddr", 32'(r_addr), 32'd3);

    // drain, then wr+rd on empty
    repeat (2) step(0, 0, 1);
    step(0, 1, 1);
    check("we_count", 32'(count), 32'd1);
    check("we_udf", 32'(underflow), 32'd1);

    // wr+rd while full: only read accepted, overflow pulses
    repeat (3) step(0, 1, 0);
    step(0, 1, 1);
    check("wf_count", 32'(count), 32'd3);
    check("wf_ovf", 32'(overflow), 32'd1);

    // reset with write at count=3
    step(1, 1, 0);
    check("rstwr_count", 32'(count), 32'd0);
    check("rstwr_empty", 32'(empty), 32'd1);
    check("rstwr_ovf", 32'(overflow), 32'd0);

    // random traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
